// File: rtl/pc_predict_unit.sv
// Fetch-PC generator with a direct-mapped BTB and 2-bit saturating counters.
// Predicts next fetch PC each cycle and redirects on execute-stage mispredicts.
module pc_predict_unit #(
  parameter int               WIDTH     = 32,
  parameter int               BTB_DEPTH = 16,
  parameter int               OPCODE_W  = 5,
  parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  output logic [WIDTH-1:0]    fetchPC,
  output logic                predTaken,
  output logic [WIDTH-1:0]    predTarget,
  input  logic                executeValid,
  input  logic [OPCODE_W-1:0] executeOpcode,
  input  logic [WIDTH-1:0]    executePC,
  input  logic [WIDTH-1:0]    executeT,
  input  logic [WIDTH-1:0]    executeA,
  input  logic [WIDTH-1:0]    executeImmediate,
  input  logic                neq,
  input  logic                lt,
  input  logic                executePredTaken,
  input  logic [WIDTH-1:0]    executePredTarget,
  output logic                flush
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = WIDTH - IDX_W;

  localparam logic [OPCODE_W-1:0] OP_J   = OPCODE_W'(5'b00001);
  localparam logic [OPCODE_W-1:0] OP_BNE = OPCODE_W'(5'b00010);
  localparam logic [OPCODE_W-1:0] OP_JAL = OPCODE_W'(5'b00011);
  localparam logic [OPCODE_W-1:0] OP_JR  = OPCODE_W'(5'b00100);
  localparam logic [OPCODE_W-1:0] OP_BLT = OPCODE_W'(5'b00110);

  typedef enum logic [1:0] {CF_NONE, CF_COND, CF_UNCOND} cf_class_e;

  logic [WIDTH-1:0]     r_pc;
  logic [BTB_DEPTH-1:0] r_valid;
  logic [1:0]           r_ctr    [BTB_DEPTH];
  logic [TAG_W-1:0]     r_tag    [BTB_DEPTH];
  logic [WIDTH-1:0]     r_target [BTB_DEPTH];

  // Fetch-side lookup
  logic [IDX_W-1:0] w_f_idx;
  logic             w_f_hit;
  logic [WIDTH-1:0] w_pc_inc;

  assign w_f_idx    = r_pc[IDX_W-1:0];
  assign w_f_hit    = r_valid[w_f_idx] && (r_tag[w_f_idx] == r_pc[WIDTH-1:IDX_W]);
  assign w_pc_inc   = r_pc + WIDTH'(1);
  assign fetchPC    = r_pc;
  assign predTaken  = w_f_hit && r_ctr[w_f_idx][1];
  assign predTarget = predTaken ? r_target[w_f_idx] : w_pc_inc;

  // Execute-side resolution
  cf_class_e        w_class;
  logic             w_taken;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_seq;
  logic [WIDTH-1:0] w_br;
  logic [WIDTH-1:0] w_correct;
  logic             w_mispredict;
  logic [IDX_W-1:0] w_e_idx;
  logic             w_e_hit;
  logic             w_tt_we;

  assign w_seq = executePC + WIDTH'(1);
  assign w_br  = w_seq + executeImmediate;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_class  = CF_NONE;
    w_taken  = 1'b0;
    w_target = w_seq;
    if (executeValid) begin
      case (executeOpcode)
        OP_J, OP_JAL: begin w_class = CF_UNCOND; w_taken = 1'b1; w_target = executeT; end
        OP_JR:        begin w_class = CF_UNCOND; w_taken = 1'b1; w_target = executeA; end
        OP_BNE:       begin w_class = CF_COND;   w_taken = neq;  w_target = w_br;     end
        OP_BLT:       begin w_class = CF_COND;   w_taken = lt;   w_target = w_br;     end
        default:      ;
      endcase
    end
  end

  assign w_correct    = w_taken ? w_target : w_seq;
  assign w_mispredict = executeValid &&
                        ((w_taken != executePredTaken) ||
                         (w_taken && (w_target != executePredTarget)));
  assign flush        = w_mispredict;

  assign w_e_idx = executePC[IDX_W-1:0];
  assign w_e_hit = r_valid[w_e_idx] && (r_tag[w_e_idx] == executePC[WIDTH-1:IDX_W]);
  assign w_tt_we = (w_class != CF_NONE) && w_taken;

  // NOTE: sequential state uses non-blocking assignments so all reads in this
  // cycle see pre-edge values (this is also what gives old-data-on-collision).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_valid <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) r_ctr[i] <= 2'b01;
    end else begin
      if (w_mispredict)  r_pc <= w_correct;
      else if (!stall)   r_pc <= predTarget;

      case (w_class)
        CF_COND: begin
          if (w_e_hit) begin
            if (w_taken && r_ctr[w_e_idx] != 2'b11)
              r_ctr[w_e_idx] <= r_ctr[w_e_idx] + 2'd1;
            else if (!w_taken && r_ctr[w_e_idx] != 2'b00)
              r_ctr[w_e_idx] <= r_ctr[w_e_idx] - 2'd1;
          end else if (w_taken) begin
            r_valid[w_e_idx] <= 1'b1;
            r_ctr[w_e_idx]   <= 2'b10;
          end
        end
        CF_UNCOND: begin
          r_valid[w_e_idx] <= 1'b1;
          r_ctr[w_e_idx]   <= 2'b11;
        end
        default: begin
          // Stale hit on a non-control instruction: drop the entry.
          if (executeValid && w_e_hit) r_valid[w_e_idx] <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: tag/target storage is not reset; valid bits gate every use of it.
  always_ff @(posedge clock) begin
    if (w_tt_we) begin
      r_tag[w_e_idx]    <= executePC[WIDTH-1:IDX_W];
      r_target[w_e_idx] <= w_target;
    end
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed self-checking bench for pc_predict_unit (WIDTH=32, BTB_DEPTH=16, RESET_PC=0).
module tb_pc_predict_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] fetchPC;
  logic        predTaken;
  logic [31:0] predTarget;
  logic        executeValid;
  logic [4:0]  executeOpcode;
  logic [31:0] executePC, executeT, executeA, executeImmediate;
  logic        neq, lt;
  logic        executePredTaken;
  logic [31:0] executePredTarget;
  logic        flush;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [4:0] OP_NOP = 5'b00000;
  localparam logic [4:0] OP_J   = 5'b00001;
  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_JAL = 5'b00011;
  localparam logic [4:0] OP_JR  = 5'b00100;
  localparam logic [4:0] OP_BLT = 5'b00110;

  pc_predict_unit #(.WIDTH(32), .BTB_DEPTH(16), .OPCODE_W(5), .RESET_PC(32'd0)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .fetchPC(fetchPC), .predTaken(predTaken), .predTarget(predTarget),
    .executeValid(executeValid), .executeOpcode(executeOpcode),
    .executePC(executePC), .executeT(executeT), .executeA(executeA),
    .executeImmediate(executeImmediate), .neq(neq), .lt(lt),
    .executePredTaken(executePredTaken), .executePredTarget(executePredTarget),
    .flush(flush)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_exec();
    executeValid      = 1'b0;
    executeOpcode     = OP_NOP;
    executePC         = '0;
    executeT          = '0;
    executeA          = '0;
    executeImmediate  = '0;
    neq               = 1'b0;
    lt                = 1'b0;
    executePredTaken  = 1'b0;
    executePredTarget = '0;
  endtask

  task automatic drive_exec(input logic [4:0] op, input logic [31:0] pc,
                            input logic [31:0] t, input logic [31:0] a,
                            input logic [31:0] imm, input logic n, input logic l,
                            input logic ptk, input logic [31:0] ptg);
    executeValid      = 1'b1;
    executeOpcode     = op;
    executePC         = pc;
    executeT          = t;
    executeA          = a;
    executeImmediate  = imm;
    neq               = n;
    lt                = l;
    executePredTaken  = ptk;
    executePredTarget = ptg;
    #1;
  endtask

  // Force fetchPC to pc via a non-control instruction at pc-1 that claims taken.
  task automatic redirect(input logic [31:0] pc);
    drive_exec(OP_NOP, pc - 32'd1, '0, '0, '0, 1'b0, 1'b0, 1'b1, 32'hDEAD);
    tick();
    idle_exec();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    stall = 1'b0;
    idle_exec();
    tick();
    tick();
    if (fetchPC !== 32'd0) begin $display("FAIL rst_pc: got %h want %h", fetchPC, 32'd0); n_fail++; end
    n_checks++;
    if (predTaken !== 1'b0) begin $display("FAIL rst_ptk: got %b want 0", predTaken); n_fail++; end
    n_checks++;
    if (predTarget !== 32'd1) begin $display("FAIL rst_ptg: got %h want %h", predTarget, 32'd1); n_fail++; end
    n_checks++;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (fetchPC !== 32'(i)) begin $display("FAIL idle_pc[%0d]: got %h want %h", i, fetchPC, 32'(i)); n_fail++; end
      n_checks++;
      if (predTaken !== 1'b0 || flush !== 1'b0) begin
        $display("FAIL idle_ptk_flush[%0d]: got %b/%b want 0/0", i, predTaken, flush); n_fail++;
      end
      n_checks++;
      tick();
    end
  endtask

  task automatic test_cold_bne();
    drive_exec(OP_BNE, 32'd5, '0, '0, 32'd3, 1'b1, 1'b0, 1'b0, 32'd6);
    if (flush !== 1'b1) begin $display("FAIL cold_flush: got %b want 1", flush); n_fail++; end
    n_checks++;
    tick(); idle_exec(); #1;
    if (fetchPC !== 32'd9) begin $display("FAIL cold_pc: got %h want %h", fetchPC, 32'd9); n_fail++; end
    n_checks++;
    if (dut.r_valid[5] !== 1'b1 || dut.r_ctr[5] !== 2'b10) begin
      $display("FAIL cold_alloc: got v=%b c=%b want v=1 c=10", dut.r_valid[5], dut.r_ctr[5]); n_fail++;
    end
    n_checks++;
    redirect(32'd5);
    if (predTaken !== 1'b1 || predTarget !== 32'd9) begin
      $display("FAIL cold_refetch: got %b/%h want 1/%h", predTaken, predTarget, 32'd9); n_fail++;
    end
    n_checks++;
    drive_exec(OP_BNE, 32'd5, '0, '0, 32'd3, 1'b1, 1'b0, 1'b1, 32'd9);
    if (flush !== 1'b0) begin $display("FAIL cold_agree_flush: got %b want 0", flush); n_fail++; end
    n_checks++;
    tick(); idle_exec(); #1;
    if (fetchPC !== 32'd9 || dut.r_ctr[5] !== 2'b11) begin
      $display("FAIL cold_agree_state: got pc=%h c=%b want pc=%h c=11", fetchPC, dut.r_ctr[5], 32'd9); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_trained_bne();
    drive_exec(OP_BNE, 32'd5, '0, '0, 32'd3, 1'b0, 1'b0, 1'b1, 32'd9);
    if (flush !== 1'b1) begin $display("FAIL nt1_flush: got %b want 1", flush); n_fail++; end
    n_checks++;
    tick(); idle_exec(); #1;
    if (fetchPC !== 32'd6 || dut.r_ctr[5] !== 2'b10) begin
      $display("FAIL nt1_state: got pc=%h c=%b want pc=%h c=10", fetchPC, dut.r_ctr[5], 32'd6); n_fail++;
    end
    n_checks++;
    drive_exec(OP_BNE, 32'd5, '0, '0, 32'd3, 1'b0, 1'b0, 1'b1, 32'd9);
    if (flush !== 1'b1) begin $display("FAIL nt2_flush: got %b want 1", flush); n_fail++; end
    n_checks++;
    tick(); idle_exec(); #1;
    if (fetchPC !== 32'd6 || dut.r_ctr[5] !== 2'b01) begin
      $display("FAIL nt2_state: got pc=%h c=%b want pc=%h c=01", fetchPC, dut.r_ctr[5], 32'd6); n_fail++;
    end
    n_checks++;
    redirect(32'd5);
    if (predTaken !== 1'b0 || predTarget !== 32'd6) begin
      $display("FAIL nt2_predict: got %b/%h want 0/%h", predTaken, predTarget, 32'd6); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_stall();
    stall = 1'b1;
    drive_exec(OP_NOP, 32'h20, '0, '0, '0, 1'b0, 1'b0, 1'b1, 32'h77);
    if (flush !== 1'b1) begin $display("FAIL stall_mp_flush: got %b want 1", flush); n_fail++; end
    n_checks++;
    tick(); idle_exec(); #1;
    if (fetchPC !== 32'h21) begin $display("FAIL stall_mp_pc: got %h want %h", fetchPC, 32'h21); n_fail++; end
    n_checks++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (fetchPC !== 32'h21 || predTaken !== 1'b0 || predTarget !== 32'h22) begin
        $display("FAIL stall_hold[%0d]: got %h/%b/%h want %h/0/%h", i, fetchPC, predTaken, predTarget, 32'h21, 32'h22);
        n_fail++;
      end
      n_checks++;
    end
    stall = 1'b0;
  endtask

  task automatic test_bubble();
    // A taken-looking bne in a bubble must neither flush nor train.
    drive_exec(OP_BNE, 32'd5, '0, '0, 32'd3, 1'b1, 1'b0, 1'b0, 32'd6);
    executeValid = 1'b0;
    #1;
    if (flush !== 1'b0) begin $display("FAIL bubble_flush: got %b want 0", flush); n_fail++; end
    n_checks++;
    tick(); idle_exec(); #1;
    if (dut.r_ctr[5] !== 2'b01) begin $display("FAIL bubble_ctr: got %b want 01", dut.r_ctr[5]); n_fail++; end
    n_checks++;
  endtask

  task automatic test_jr();
    drive_exec(OP_JR, 32'd7, '0, 32'h40, '0, 1'b0, 1'b0, 1'b0, 32'd8);
    if (flush !== 1'b1) begin $display("FAIL jr1_flush: got %b want 1", flush); n_fail++; end
    n_checks++;
    tick(); idle_exec(); #1;
    if (fetchPC !== 32'h40 || dut.r_ctr[7] !== 2'b11) begin
      $display("FAIL jr1_state: got pc=%h c=%b want pc=%h c=11", fetchPC, dut.r_ctr[7], 32'h40); n_fail++;
    end
    n_checks++;
    drive_exec(OP_JR, 32'd7, '0, 32'h80, '0, 1'b0, 1'b0, 1'b1, 32'h40);
    if (flush !== 1'b1) begin $display("FAIL jr2_flush: got %b want 1", flush); n_fail++; end
    n_checks++;
    tick(); idle_exec(); #1;
    if (fetchPC !== 32'h80) begin $display("FAIL jr2_pc: got %h want %h", fetchPC, 32'h80); n_fail++; end
    n_checks++;
    redirect(32'd7);
    if (predTaken !== 1'b1 || predTarget !== 32'h80) begin
      $display("FAIL jr2_retarget: got %b/%h want 1/%h", predTaken, predTarget, 32'h80); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_wrap();
    drive_exec(OP_BLT, 32'h0A, '0, '0, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 32'h0B);
    if (flush !== 1'b1) begin $display("FAIL blt_flush: got %b want 1", flush); n_fail++; end
    n_checks++;
    tick(); idle_exec(); #1;
    if (fetchPC !== 32'h09) begin $display("FAIL blt_neg_imm_pc: got %h want %h", fetchPC, 32'h09); n_fail++; end
    n_checks++;
    drive_exec(OP_NOP, 32'hFFFF_FFFF, '0, '0, '0, 1'b0, 1'b0, 1'b1, 32'h5);
    tick(); idle_exec(); #1;
    if (fetchPC !== 32'h0) begin $display("FAIL seq_wrap_pc: got %h want %h", fetchPC, 32'h0); n_fail++; end
    n_checks++;
  endtask

  task automatic test_alias_collision();
    drive_exec(OP_J, 32'd2, 32'h30, '0, '0, 1'b0, 1'b0, 1'b0, 32'd3);
    if (flush !== 1'b1) begin $display("FAIL j_flush: got %b want 1", flush); n_fail++; end
    n_checks++;
    tick(); idle_exec(); #1;
    if (fetchPC !== 32'h30) begin $display("FAIL j_pc: got %h want %h", fetchPC, 32'h30); n_fail++; end
    n_checks++;
    redirect(32'd18);
    if (predTaken !== 1'b0 || predTarget !== 32'd19) begin
      $display("FAIL alias_miss: got %b/%h want 0/%h", predTaken, predTarget, 32'd19); n_fail++;
    end
    n_checks++;
    redirect(32'd2);
    if (predTaken !== 1'b1 || predTarget !== 32'h30) begin
      $display("FAIL alias_hit: got %b/%h want 1/%h", predTaken, predTarget, 32'h30); n_fail++;
    end
    n_checks++;
    stall = 1'b1;
    drive_exec(OP_J, 32'd2, 32'h50, '0, '0, 1'b0, 1'b0, 1'b1, 32'h50);
    if (flush !== 1'b0 || fetchPC !== 32'd2 || predTarget !== 32'h30) begin
      $display("FAIL coll_old: got f=%b pc=%h tg=%h want f=0 pc=%h tg=%h", flush, fetchPC, predTarget, 32'd2, 32'h30);
      n_fail++;
    end
    n_checks++;
    tick(); idle_exec(); #1;
    if (fetchPC !== 32'd2 || predTarget !== 32'h50) begin
      $display("FAIL coll_new: got pc=%h tg=%h want pc=%h tg=%h", fetchPC, predTarget, 32'd2, 32'h50); n_fail++;
    end
    n_checks++;
    drive_exec(OP_NOP, 32'd2, '0, '0, '0, 1'b0, 1'b0, 1'b1, 32'h50);
    if (flush !== 1'b1) begin $display("FAIL stale_flush: got %b want 1", flush); n_fail++; end
    n_checks++;
    tick(); idle_exec(); #1;
    if (fetchPC !== 32'd3 || dut.r_valid[2] !== 1'b0) begin
      $display("FAIL stale_inval: got pc=%h v=%b want pc=%h v=0", fetchPC, dut.r_valid[2], 32'd3); n_fail++;
    end
    n_checks++;
    stall = 1'b0;
  endtask

  task automatic test_reset_mid();
    redirect(32'd7);
    if (predTaken !== 1'b1) begin $display("FAIL pre_rst_hit: got %b want 1", predTaken); n_fail++; end
    n_checks++;
    drive_exec(OP_JAL, 32'd12, 32'h99, '0, '0, 1'b0, 1'b0, 1'b0, 32'd13);
    #1;
    reset = 1'b1;
    #1;
    if (fetchPC !== 32'd0 || predTaken !== 1'b0 || predTarget !== 32'd1 || dut.r_valid !== 16'h0) begin
      $display("FAIL mid_rst: got pc=%h ptk=%b tg=%h v=%h want pc=0 ptk=0 tg=1 v=0",
               fetchPC, predTaken, predTarget, dut.r_valid);
      n_fail++;
    end
    n_checks++;
    idle_exec();
    tick();
    reset = 1'b0;
    #1;
    if (fetchPC !== 32'd0) begin $display("FAIL post_rst_pc: got %h want 0", fetchPC); n_fail++; end
    n_checks++;
    redirect(32'd7);
    if (predTaken !== 1'b0 || predTarget !== 32'd8) begin
      $display("FAIL post_rst_cleared: got %b/%h want 0/%h", predTaken, predTarget, 32'd8); n_fail++;
    end
    n_checks++;
    if (dut.r_ctr[5] !== 2'b01) begin $display("FAIL post_rst_ctr: got %b want 01", dut.r_ctr[5]); n_fail++; end
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_cold_bne();
    test_trained_bne();
    test_stall();
    test_bubble();
    test_jr();
    test_wrap();
    test_alias_collision();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
